son3_frame_packer: RTL and testbench

- Sits directly downstream of the parent's dout_of_son3 output.
- Buffers 16-bit result samples in a small FIFO and packs them into fixed-length frames. Each frame is one header word followed by FRAME_LEN payload words.
- Frames leave on a valid/ready stream with SOP/EOP markers.
- Reports FIFO level and a sticky overflow flag for status readback.

---
 rtl/son3_frame_packer.sv | 194 +++++++++++++++++++
 tb/tb_son3_frame_packer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/son3_frame_packer.sv
// son3_frame_packer: buffers dout_of_son3 samples in a FIFO and
// emits header + FRAME_LEN payload frames on a valid/ready stream.
module son3_frame_packer #(
  parameter int DW        = 16,
  parameter int DEPTH     = 16,
  parameter int FRAME_LEN = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_en,
  input  logic [3:0]                 cfg_hdr_id,
  input  logic                       din_vld,
  input  logic [DW-1:0]              din,
  output logic                       dout_vld,
  input  logic                       dout_rdy,
  output logic [DW-1:0]              dout,
  output logic                       dout_sop,
  output logic                       dout_eop,
  output logic [$clog2(DEPTH):0]     fifo_lvl,
  output logic                       ovf_flag,
  input  logic                       ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_FRAME = LW'(FRAME_LEN);
  localparam logic [LW-1:0] PCNT_LAST = LW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] lvl;

  logic [3:0]    hdr_id;
  logic [7:0]    frame_cnt;
  logic [LW-1:0] pcnt;

  logic          out_load;
  logic          wr_en;
  logic          full;
  logic          pop;
  logic          last_word;
  logic          take_frame;
  logic          ld_hdr;
  logic          ld_pay;
  logic [DW-1:0] hdr_word;

  // Handshake and FIFO side conditions.
  always_comb begin
    out_load   = !dout_vld || dout_rdy;
    full       = (lvl == LVL_FULL);
    wr_en      = din_vld && !full;
    last_word  = (pcnt == PCNT_LAST);
    take_frame = cfg_en && (lvl >= LVL_FRAME);
    hdr_word   = DW'({4'hA, hdr_id, frame_cnt});
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (take_frame) state_nx = HDR;
      end
      HDR: begin
        if (out_load) state_nx = PAYLOAD;
      end
      PAYLOAD: begin
        if (out_load && last_word) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // FSM output decode: which word the output register takes.
  always_comb begin
    ld_hdr = 1'b0;
    ld_pay = 1'b0;
    unique case (state)
      HDR:     ld_hdr = out_load;
      PAYLOAD: ld_pay = out_load;
      default: begin
        ld_hdr = 1'b0;
        ld_pay = 1'b0;
      end
    endcase
    pop = ld_pay;
  end

  // FIFO storage; contents need no reset, pointers guard them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= din;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      lvl    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      unique case ({wr_en, pop})
        2'b10:   lvl <= lvl + LW'(1);
        2'b01:   lvl <= lvl - LW'(1);
        default: lvl <= lvl;
      endcase
    end
  end

  // Sticky overflow; a drop in the same cycle beats the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_flag <= 1'b0;
    end else if (din_vld && full) begin
      ovf_flag <= 1'b1;
    end else if (ovf_clr) begin
      ovf_flag <= 1'b0;
    end
  end

  // Frame bookkeeping: stream id, frame number, payload index.
  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_id    <= '0;
      frame_cnt <= '0;
      pcnt      <= '0;
    end else begin
      if (state == IDLE && take_frame) begin
        hdr_id <= cfg_hdr_id;
      end
      if (ld_hdr) begin
        pcnt <= '0;
      end else if (ld_pay) begin
        if (last_word) begin
          pcnt      <= '0;
          frame_cnt <= frame_cnt + 8'd1;
        end else begin
          pcnt <= pcnt + LW'(1);
        end
      end
    end
  end

  // Output register; holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_vld <= 1'b0;
      dout     <= '0;
      dout_sop <= 1'b0;
      dout_eop <= 1'b0;
    end else if (ld_hdr) begin
      dout_vld <= 1'b1;
      dout     <= hdr_word;
      dout_sop <= 1'b1;
      dout_eop <= 1'b0;
    end else if (ld_pay) begin
      dout_vld <= 1'b1;
      dout     <= mem[rd_ptr];
      dout_sop <= 1'b0;
      dout_eop <= last_word;
    end else if (out_load) begin
      dout_vld <= 1'b0;
      dout_sop <= 1'b0;
      dout_eop <= 1'b0;
    end
  end

  assign fifo_lvl = lvl;

endmodule

// File: tb/tb_son3_frame_packer.sv
// tb_son3_frame_packer: directed vectors for the frame packer.
// Transfers are collected at negedge and compared against tables.
module tb_son3_frame_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_en;
  logic [3:0]  cfg_hdr_id;
  logic        din_vld;
  logic [15:0] din;
  logic        dout_vld;
  logic        dout_rdy;
  logic [15:0] dout;
  logic        dout_sop;
  logic        dout_eop;
  logic [4:0]  fifo_lvl;
  logic        ovf_flag;
  logic        ovf_clr;

  son3_frame_packer #(
    .DW(16), .DEPTH(16), .FRAME_LEN(8)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_en(cfg_en), .cfg_hdr_id(cfg_hdr_id),
    .din_vld(din_vld), .din(din),
    .dout_vld(dout_vld), .dout_rdy(dout_rdy),
    .dout(dout), .dout_sop(dout_sop), .dout_eop(dout_eop),
    .fifo_lvl(fifo_lvl), .ovf_flag(ovf_flag), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] din;
    logic [15:0] dout;
    logic        sop;
    logic        eop;
  } vec_t;

  typedef struct packed {
    logic [15:0] d;
    logic        sop;
    logic        eop;
  } wd_t;

  wd_t  q [$];
  int   checks   = 0;
  int   failures = 0;

  logic       bp_on = 1'b0;
  logic [3:0] bp_pat = 4'b1001;
  int         bp_ph = 0;

  logic        p_rst = 1'b1;
  logic        p_vld = 1'b0;
  logic        p_rdy = 1'b0;
  logic [15:0] p_d   = '0;
  logic        p_sop = 1'b0;
  logic        p_eop = 1'b0;

  // Output monitor: stall stability and transfer capture.
  always @(negedge clk) begin
    if (!rst && !p_rst && p_vld && !p_rdy) begin
      checks++;
      if (dout_vld !== 1'b1 || dout !== p_d ||
          dout_sop !== p_sop || dout_eop !== p_eop) begin
        failures++;
        $display("FAIL stall_hold: got vld=%b d=%h s=%b e=%b want vld=1 d=%h s=%b e=%b",
                 dout_vld, dout, dout_sop, dout_eop, p_d, p_sop, p_eop);
      end
    end
    if (!rst && dout_vld && dout_rdy) begin
      q.push_back({dout, dout_sop, dout_eop});
    end
    p_rst = rst;
    p_vld = dout_vld;
    p_rdy = dout_rdy;
    p_d   = dout;
    p_sop = dout_sop;
    p_eop = dout_eop;
  end

  // Backpressure pattern 1,0,0,1 repeating.
  always begin
    @(posedge clk);
    #1;
    if (bp_on) begin
      dout_rdy = bp_pat[bp_ph];
      bp_ph    = (bp_ph + 1) % 4;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_q(input string nm, input int n, input int budget);
    int k = 0;
    while (q.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk({nm, "_timeout"}, 32'(q.size() >= n), 32'd1);
  endtask

  task automatic pop_chk(input string nm, input logic [15:0] d,
                         input logic sop, input logic eop);
    wd_t w;
    if (q.size() == 0) begin
      chk({nm, "_missing"}, 32'd0, 32'd1);
    end else begin
      w = q.pop_front();
      chk({nm, "_word"}, 32'({w.d, w.sop, w.eop}),
          32'({d, sop, eop}));
    end
  endtask

  task automatic exp_frame(input string nm, input logic [3:0] id,
                           input logic [7:0] fc,
                           input logic [15:0] base);
    pop_chk({nm, "_hdr"}, {4'hA, id, fc}, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      pop_chk({nm, "_pay"}, base + 16'(i), 1'b0, i == 7);
    end
  endtask

  task automatic write_samples(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      din_vld = 1'b1;
      din     = base + 16'(i);
      tick();
    end
    din_vld = 1'b0;
  endtask

  vec_t tbl [9];

  initial begin
    int n;
    int cyc;

    tbl[0] = '{din: 16'h0000, dout: 16'hA300, sop: 1'b1, eop: 1'b0};
    for (int i = 1; i <= 8; i++) begin
      tbl[i] = '{din: 16'(i), dout: 16'(i), sop: 1'b0, eop: i == 8};
    end

    rst        = 1'b1;
    cfg_en     = 1'b0;
    cfg_hdr_id = 4'h0;
    din_vld    = 1'b0;
    din        = '0;
    dout_rdy   = 1'b1;
    ovf_clr    = 1'b0;
    tick();
    tick();

    chk("rst_vld", 32'(dout_vld), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_sop", 32'(dout_sop), 32'd0);
    chk("rst_eop", 32'(dout_eop), 32'd0);
    chk("rst_lvl", 32'(fifo_lvl), 32'd0);
    chk("rst_ovf", 32'(ovf_flag), 32'd0);
    rst = 1'b0;
    tick();

    // Basic frame with latency and back-to-back payload.
    cfg_en     = 1'b1;
    cfg_hdr_id = 4'h3;
    for (int i = 1; i <= 8; i++) begin
      din_vld = 1'b1;
      din     = tbl[i].din;
      tick();
    end
    din_vld = 1'b0;
    chk("lat_lvl", 32'(fifo_lvl), 32'd8);
    chk("lat_vld_n2", 32'(dout_vld), 32'd0);
    tick();
    chk("lat_vld_n2b", 32'(dout_vld), 32'd0);
    tick();
    chk("lat_hdr_vld", 32'(dout_vld), 32'd1);
    chk("lat_hdr_sop", 32'(dout_sop), 32'd1);
    chk("lat_hdr_word", 32'(dout), 32'h0000A300);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("b2b_vld", 32'(dout_vld), 32'd1);
    end
    tick();
    chk("gap_vld", 32'(dout_vld), 32'd0);
    chk("end_lvl", 32'(fifo_lvl), 32'd0);
    chk("t1_count", 32'(q.size()), 32'd9);
    for (int i = 0; i < 9; i++) begin
      pop_chk("t1", tbl[i].dout, tbl[i].sop, tbl[i].eop);
    end
    q.delete();

    // Backpressure: same words, held stable during stalls.
    bp_on = 1'b1;
    write_samples(16'h0001, 8);
    wait_q("t2", 9, 100);
    bp_on = 1'b0;
    tick();
    dout_rdy = 1'b1;
    tick();
    exp_frame("t2", 4'h3, 8'h01, 16'h0001);
    chk("t2_lvl", 32'(fifo_lvl), 32'd0);
    q.delete();

    // Overflow with cfg_en low.
    cfg_en = 1'b0;
    write_samples(16'h0101, 20);
    chk("ovf_lvl", 32'(fifo_lvl), 32'd16);
    chk("ovf_set", 32'(ovf_flag), 32'd1);
    ovf_clr = 1'b1;
    din_vld = 1'b1;
    din     = 16'h0115;
    tick();
    din_vld = 1'b0;
    chk("ovf_prio", 32'(ovf_flag), 32'd1);
    chk("ovf_lvl2", 32'(fifo_lvl), 32'd16);
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr", 32'(ovf_flag), 32'd0);
    cfg_en     = 1'b1;
    cfg_hdr_id = 4'h5;
    wait_q("t3", 18, 100);
    exp_frame("t3a", 4'h5, 8'h02, 16'h0101);
    exp_frame("t3b", 4'h5, 8'h03, 16'h0109);
    tick();
    chk("t3_lvl", 32'(fifo_lvl), 32'd0);
    q.delete();

    // Reset mid-frame.
    cfg_hdr_id = 4'h3;
    write_samples(16'h0201, 8);
    tick();
    tick();
    chk("t5_hdr", 32'(dout), 32'h0000A304);
    tick();
    tick();
    tick();
    chk("t5_pay3", 32'(dout), 32'h00000203);
    rst = 1'b1;
    tick();
    chk("t5_vld", 32'(dout_vld), 32'd0);
    chk("t5_lvl", 32'(fifo_lvl), 32'd0);
    rst = 1'b0;
    q.delete();
    tick();
    write_samples(16'h0301, 8);
    wait_q("t5", 9, 50);
    exp_frame("t5", 4'h3, 8'h00, 16'h0301);
    q.delete();

    // cfg_en drops after SOP.
    cfg_hdr_id = 4'h7;
    write_samples(16'h0401, 8);
    n = 0;
    while (!(dout_vld && dout_sop) && n < 20) begin
      tick();
      n++;
    end
    chk("t6_sop_seen", 32'(dout_vld && dout_sop), 32'd1);
    cfg_en = 1'b0;
    write_samples(16'h0501, 8);
    for (int i = 0; i < 40; i++) tick();
    chk("t6_count", 32'(q.size()), 32'd9);
    exp_frame("t6", 4'h7, 8'h01, 16'h0401);
    chk("t6_lvl", 32'(fifo_lvl), 32'd8);
    chk("t6_vld", 32'(dout_vld), 32'd0);
    q.delete();

    // frame_cnt wrap after 256 frames.
    rst = 1'b1;
    tick();
    rst        = 1'b0;
    cfg_en     = 1'b1;
    cfg_hdr_id = 4'hC;
    q.delete();
    fork
      begin
        int wc = 0;
        cyc = 0;
        while (wc < 257 * 8 && cyc < 20000) begin
          @(posedge clk);
          #1;
          cyc++;
          if (fifo_lvl < 5'd16) begin
            din_vld = 1'b1;
            din     = 16'(wc + 1);
            wc++;
          end else begin
            din_vld = 1'b0;
          end
        end
        @(posedge clk);
        #1;
        din_vld = 1'b0;
      end
    join_none
    for (int f = 0; f <= 256; f++) begin
      wait_q("t4", 9, 300);
      exp_frame("t4", 4'hC, 8'(f), 16'(f * 8 + 1));
    end
    chk("t4_last_hdr_seen", 32'(checks > 0), 32'd1);
    chk("t4_ovf", 32'(ovf_flag), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
